// File: rtl/vfpu_engine.sv
// Streaming FP32 min/max, sign-injection and compare engine with a 2-stage join pipeline.
// Define VFPU_ENGINE_FFLAGS_EN to build the sticky invalid-operation (nv_o) logic.
module vfpu_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  nv_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    localparam logic [2:0] OP_MIN   = 3'd0;
    localparam logic [2:0] OP_MAX   = 3'd1;
    localparam logic [2:0] OP_SGNJ  = 3'd2;
    localparam logic [2:0] OP_SGNJN = 3'd3;
    localparam logic [2:0] OP_SGNJX = 3'd4;
    localparam logic [2:0] OP_FEQ   = 3'd5;
    localparam logic [2:0] OP_FLT   = 3'd6;
    localparam logic [2:0] OP_FLE   = 3'd7;
    localparam logic [DATA_WIDTH-1:0] CANON_NAN = 32'h7FC0_0000;

    state_e                 state_q, state_d;
    logic [2:0]             op_q;
    logic [LEN_WIDTH-1:0]   len_q, in_cnt_q, out_cnt_q;
    logic                   s1_valid_q, s2_valid_q;
    logic [DATA_WIDTH-1:0]  s1_a_q, s1_b_q, s2_data_q;
    logic [DATA_WIDTH-1:0]  result_d;

    logic s2_adv, s1_adv, in_ok, in_fire, out_fire, job_start;

    assign s2_adv    = ~s2_valid_q | r_ready_i;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign in_ok     = (state_q == ST_RUN) & (in_cnt_q < len_q) & s1_adv;
    assign in_fire   = a_valid_i & b_valid_i & in_ok;
    assign out_fire  = s2_valid_q & r_ready_i;
    assign job_start = (state_q == ST_IDLE) & start_i;

    // Each ready depends on the other side's valid so the two streams only ever fire together.
    assign a_ready_o = b_valid_i & in_ok;
    assign b_ready_o = a_valid_i & in_ok;
    assign r_data_o  = s2_data_q;
    assign r_valid_o = s2_valid_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (out_fire && (out_cnt_q + LEN_WIDTH'(1) == len_q)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand classification on the stage-1 registers.
    logic a_nan, b_nan, any_nan, both_zero, mag_lt, mag_gt, lt_tot, eq;
    assign a_nan     = (&s1_a_q[30:23]) & (|s1_a_q[22:0]);
    assign b_nan     = (&s1_b_q[30:23]) & (|s1_b_q[22:0]);
    assign any_nan   = a_nan | b_nan;
    assign both_zero = ((s1_a_q[30:0] | s1_b_q[30:0]) == 31'd0);
    assign mag_lt    = s1_a_q[30:0] < s1_b_q[30:0];
    assign mag_gt    = s1_a_q[30:0] > s1_b_q[30:0];
    // Total order on non-NaN values where -0 sorts below +0; compares strip that with both_zero.
    assign lt_tot    = (s1_a_q[31] != s1_b_q[31]) ? s1_a_q[31] : (s1_a_q[31] ? mag_gt : mag_lt);
    assign eq        = (s1_a_q == s1_b_q) | both_zero;

    always_comb begin
        result_d = '0;
        case (op_q)
            OP_MIN, OP_MAX: begin
                if (a_nan & b_nan)  result_d = CANON_NAN;
                else if (a_nan)     result_d = s1_b_q;
                else if (b_nan)     result_d = s1_a_q;
                else if (op_q == OP_MIN) result_d = lt_tot ? s1_a_q : s1_b_q;
                else                result_d = lt_tot ? s1_b_q : s1_a_q;
            end
            OP_SGNJ:  result_d = {s1_b_q[31], s1_a_q[30:0]};
            OP_SGNJN: result_d = {~s1_b_q[31], s1_a_q[30:0]};
            OP_SGNJX: result_d = {s1_a_q[31] ^ s1_b_q[31], s1_a_q[30:0]};
            OP_FEQ:   result_d = {31'd0, ~any_nan & eq};
            OP_FLT:   result_d = {31'd0, ~any_nan & lt_tot & ~both_zero};
            OP_FLE:   result_d = {31'd0, ~any_nan & (eq | lt_tot)};
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (job_start) begin
                op_q      <= op_i;
                len_q     <= len_i;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (in_fire)  in_cnt_q  <= in_cnt_q + LEN_WIDTH'(1);
                if (out_fire) out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
            end
            if (s1_adv) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_a_q <= a_data_i;
                    s1_b_q <= b_data_i;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= result_d;
            end
        end
    end

`ifdef VFPU_ENGINE_FFLAGS_EN
    logic a_snan, b_snan, elem_nv_d, s2_nv_q, nv_q;
    assign a_snan = a_nan & ~s1_a_q[22];
    assign b_snan = b_nan & ~s1_b_q[22];

    always_comb begin
        elem_nv_d = 1'b0;
        case (op_q)
            OP_MIN, OP_MAX, OP_FEQ: elem_nv_d = a_snan | b_snan;
            OP_FLT, OP_FLE:         elem_nv_d = any_nan;
            default:                elem_nv_d = 1'b0;
        endcase
    end

    // The flag tracks elements as they leave stage 2, so an aborted element never raises it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_nv_q <= 1'b0;
            nv_q    <= 1'b0;
        end else begin
            if (s2_adv && s1_valid_q) s2_nv_q <= elem_nv_d;
            if (job_start)                nv_q <= 1'b0;
            else if (out_fire && s2_nv_q) nv_q <= 1'b1;
        end
    end
    assign nv_o = nv_q;
`else
    assign nv_o = 1'b0;
`endif

endmodule

// File: tb/tb_vfpu_engine.sv
// Randomized scoreboard bench for vfpu_engine: a real-arithmetic model predicts each result
// and a decoupled monitor compares every result handshake in order.
module tb_vfpu_engine;
`ifdef VFPU_ENGINE_FFLAGS_EN
    localparam bit NV_EN = 1'b1;
`else
    localparam bit NV_EN = 1'b0;
`endif

    logic        clk_i, rst_i, start_i;
    logic [2:0]  op_i;
    logic [15:0] len_i;
    logic [31:0] a_data_i, b_data_i, r_data_o;
    logic        a_valid_i, b_valid_i, a_ready_o, b_ready_o;
    logic        r_valid_o, r_ready_i, busy_o, done_o, nv_o;

    vfpu_engine #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .len_i(len_i),
        .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .b_data_i(b_data_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .busy_o(busy_o), .done_o(done_o), .nv_o(nv_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ja[0:15];
    logic [31:0] jb[0:15];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    // Numeric value of a non-NaN float; infinity maps to +-2^128, beyond every finite value.
    function automatic real f2r(input logic [31:0] x);
        real m, v;
        int  e;
        e = int'(x[30:23]);
        m = real'(x[22:0]);
        if (e == 0) v = m * (2.0 ** (-149));
        else        v = (m + 8388608.0) * (2.0 ** (e - 150));
        return x[31] ? -v : v;
    endfunction

    // Returns {nv, result}.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit          nv, an, bn, lo_a;
        real         ra, rb;
        an = is_nan(a);
        bn = is_nan(b);
        ra = an ? 0.0 : f2r(a);
        rb = bn ? 0.0 : f2r(b);
        r  = 32'd0;
        nv = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                nv = is_snan(a) || is_snan(b);
                if (an && bn)    r = 32'h7FC00000;
                else if (an)     r = b;
                else if (bn)     r = a;
                else begin
                    if (ra < rb)      lo_a = 1'b1;
                    else if (rb < ra) lo_a = 1'b0;
                    else              lo_a = (a == b) ? 1'b1 : a[31];
                    r = ((op == 3'd0) == lo_a) ? a : b;
                end
            end
            3'd2: r = {b[31], a[30:0]};
            3'd3: r = {~b[31], a[30:0]};
            3'd4: r = {a[31] ^ b[31], a[30:0]};
            3'd5: begin nv = is_snan(a) || is_snan(b); r = {31'd0, !an && !bn && (ra == rb)}; end
            3'd6: begin nv = an || bn; r = {31'd0, !an && !bn && (ra < rb)}; end
            default: begin nv = an || bn; r = {31'd0, !an && !bn && (ra <= rb)}; end
        endcase
        return {nv & NV_EN, r};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = 32'h00000000;
            1: r = 32'h80000000;
            2: r = 32'h3F800000;
            3: r = 32'hBF800000;
            4: r = 32'h7FC00000;
            5: begin
                r[30:23] = 8'hFF;
                r[22] = 1'b0;
                if (r[21:0] == 22'd0) r[0] = 1'b1;
            end
            6: r = {r[31], 31'h7F800000};
            7: r[30:23] = 8'h00;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: pops one expectation per result handshake and checks that stalled results hold.
    initial begin
        bit          stall_pend;
        logic [31:0] stall_data, e;
        stall_pend = 1'b0;
        stall_data = 32'd0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    chk("stall_valid_hold", {31'd0, r_valid_o}, 32'd1);
                    chk("stall_data_hold", r_data_o, stall_data);
                end
                if (r_valid_o && r_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", r_data_o, 32'hxxxxxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        $display("result cyc=%0d data=%08h expected=%08h", cyc, r_data_o, e);
                        chk("result_data", r_data_o, e);
                    end
                    last_hs_cyc = cyc;
                end
                stall_pend = r_valid_o && !r_ready_i;
                stall_data = r_data_o;
            end
        end
    end

    task automatic start_job(input logic [2:0] op, input int len, output int start_cyc);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        op_i    = op;
        len_i   = 16'(len);
        @(negedge clk_i);
        start_cyc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i    = 3'($urandom);
        len_i   = 16'($urandom);
    endtask

    // vmode: 0 both valid, 1 a always / b on odd cycles, 2 random. rmode: 0 ready, 1 toggle, 2 random.
    task automatic run_job(input logic [2:0] op, input int len, input int vmode, input int rmode, input bit poke);
        int          i, inflight, start_cyc;
        bit          done_seen, exp_nv, fire, hs;
        logic [32:0] m;
        start_job(op, len, start_cyc);
        i = 0; inflight = 0; exp_nv = 1'b0; done_seen = 1'b0;
        for (int k = 0; k < 400 && !done_seen; k++) begin
            case (vmode)
                0: begin a_valid_i = 1'b1; b_valid_i = 1'b1; end
                1: begin a_valid_i = 1'b1; b_valid_i = (cyc % 2) == 1; end
                default: begin a_valid_i = $urandom_range(0, 3) != 0; b_valid_i = $urandom_range(0, 3) != 0; end
            endcase
            a_data_i  = (i < len) ? ja[i] : $urandom;
            b_data_i  = (i < len) ? jb[i] : $urandom;
            r_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 2) == 0) : 1'($urandom);
            start_i   = poke && (k == 3);
            if (poke && k == 3) begin
                op_i  = op ^ 3'd5;
                len_i = 16'd3;
            end
            @(negedge clk_i);
            hs   = r_valid_o && r_ready_i;
            fire = a_valid_i && b_valid_i && a_ready_o && b_ready_o;
            if (a_ready_o) chk("a_ready_needs_b_valid", {31'd0, b_valid_i}, 32'd1);
            if (b_ready_o) chk("b_ready_needs_a_valid", {31'd0, a_valid_i}, 32'd1);
            if (a_valid_i && b_valid_i) chk("ready_pair", {31'd0, a_ready_o}, {31'd0, b_ready_o});
            if (inflight == 2 && !r_ready_i) chk("ready_drop_full", {30'd0, a_ready_o, b_ready_o}, 32'd0);
            if (i >= len) chk("ready_drop_len", {30'd0, a_ready_o, b_ready_o}, 32'd0);
            if (fire && i < len) begin
                m = model(op, a_data_i, b_data_i);
                exp_q.push_back(m[31:0]);
                exp_nv = exp_nv | m[32];
                i++;
            end
            inflight = inflight + int'(fire) - int'(hs);
            if (done_o) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, (len == 0) ? start_cyc + 1 : last_hs_cyc + 1);
                chk("done_inputs", i, len);
                chk("done_pending", exp_q.size(), 0);
                chk("done_busy", {31'd0, busy_o}, 32'd1);
                chk("nv_at_done", {31'd0, nv_o}, {31'd0, exp_nv});
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        $display("job op=%0d len=%0d vmode=%0d rmode=%0d consumed=%0d nv=%0d", op, len, vmode, rmode, i, exp_nv);
        @(posedge clk_i); #1;
        a_valid_i = 1'b0; b_valid_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        chk("done_one_cycle", {30'd0, done_o, busy_o}, 32'd0);
        chk("nv_hold", {31'd0, nv_o}, {31'd0, exp_nv});
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {26'd0, a_ready_o, b_ready_o, r_valid_o, busy_o, done_o, nv_o}, 32'd0);
        chk({name, "_data"}, r_data_o, 32'd0);
    endtask

    task automatic fill_random();
        for (int j = 0; j < 16; j++) begin
            ja[j] = rnd_fp();
            jb[j] = rnd_fp();
        end
    endtask

    initial begin
        int          start_cyc, nres;
        logic [32:0] m;
        rst_i = 1'b1; start_i = 1'b0; op_i = 3'd0; len_i = 16'd0;
        a_data_i = 32'd0; b_data_i = 32'd0; a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset_state");
        @(posedge clk_i); #1;
        rst_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;

        ja[0] = 32'h3F800000; ja[1] = 32'h80000000; ja[2] = 32'h7FC00000; ja[3] = 32'h40000000;
        jb[0] = 32'h3F000000; jb[1] = 32'h00000000; jb[2] = 32'h40400000; jb[3] = 32'h7FC00000;
        run_job(3'd1, 4, 0, 0, 1'b0);

        ja[0] = 32'h7FA00000; ja[1] = 32'h3F800000;
        jb[0] = 32'h3F800000; jb[1] = 32'h40000000;
        run_job(3'd6, 2, 0, 0, 1'b0);

        fill_random();
        run_job(3'd4, 8, 0, 1, 1'b0);
        fill_random();
        run_job(3'd0, 10, 1, 0, 1'b0);
        run_job(3'd2, 0, 0, 0, 1'b0);
        fill_random();
        run_job(3'd5, 6, 0, 0, 1'b1);

        for (int j = 0; j < 14; j++) begin
            fill_random();
            run_job(3'($urandom), $urandom_range(1, 16), 2, 2, 1'b0);
        end

        // Abort a compare job after three results; its nv and pipeline contents must vanish.
        fill_random();
        ja[0] = 32'h7FA00000;
        start_job(3'd6, 6, start_cyc);
        nres = 0;
        a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1;
        for (int k = 0; k < 40 && nres < 3; k++) begin
            a_data_i = ja[k % 16];
            b_data_i = jb[k % 16];
            @(negedge clk_i);
            if (a_ready_o && b_ready_o) begin
                m = model(3'd6, a_data_i, b_data_i);
                exp_q.push_back(m[31:0]);
            end
            if (r_valid_o && r_ready_i) nres++;
            if (nres < 3) begin
                @(posedge clk_i); #1;
            end
        end
        chk("abort_results_seen", nres, 3);
        @(posedge clk_i); #1;
        rst_i = 1'b1; r_ready_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("abort_reset_state");
        $display("job aborted by reset after %0d results", nres);
        @(posedge clk_i); #1;
        rst_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;

        ja[0] = 32'hC0000000; jb[0] = 32'h3F800000;
        run_job(3'd0, 1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
